fetch: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of decode. Holds the fetch PC and issues word reads
//  to instruction memory over a req/ready + rvalid handshake, one request outstanding.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 48 ++++
 rtl/fetch.sv | 177 +++++++++++++++++
 tb/tb_fetch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, reset/step defaults and the buffered slot type.
// Imported by fetch and fetch_skid_buf.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_ISSUE = 2'd1,
      FETCH_WAIT  = 2'd2,
      FETCH_HOLD  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
   localparam logic [31:0] INSN_NOP         = 32'h0000_0000;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
   } fetch_slot_t;

   // Word-align a fetch target. The interface numbers bits MSB-first, so its
   // two ignored bits [30:31] are the two least-significant bits here.
   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {insn,pc} holding buffer used when a response arrives while decode is stalled.
// Latency: loaded value visible the cycle after load; full flag registered.
// Backpressure: none of its own; clear beats load beats unload.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic        unload,
   input  logic        clear,
   input  fetch_slot_t in_dat,
   output fetch_slot_t out_dat,
   output logic        full
);

   fetch_slot_t slot_q, slot_d;
   logic        full_q, full_d;

   // Next contents: a redirect clear wins, otherwise capture or release the slot.
   always_comb begin
      slot_d = slot_q;
      full_d = full_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (load) begin
         slot_d = in_dat;
         full_d = 1'b1;
      end else if (unload) begin
         full_d = 1'b0;
      end
   end

   // Slot storage and occupancy flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_q <= '{insn: INSN_NOP, pc: 32'h0};
         full_q <= 1'b0;
      end else begin
         slot_q <= slot_d;
         full_q <= full_d;
      end
   end

   assign out_dat = slot_q;
   assign full    = full_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: holds the fetch PC, issues one word read at a time, registers insn/pc to decode.
// Latency: request accepted cycle N, rvalid cycle N+k, insn_valid high cycle N+k+1.
// Backpressure: stall freezes insn/pc/insn_valid; a response arriving under stall parks in a 1-entry buffer.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] insn,
   output logic [31:0] pc,
   output logic        insn_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic [31:0]  insn_q, insn_d;
   logic [31:0]  pc_q, pc_d;
   logic         insn_valid_q, insn_valid_d;
   logic         drop_q, drop_d;

   logic         buf_load, buf_unload, buf_clear, buf_full;
   logic         delivered;
   fetch_slot_t  buf_in, buf_out;

   assign buf_in = '{insn: imem_rdata, pc: req_pc_q};

   fetch_skid_buf u_skid (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (buf_load),
      .unload  (buf_unload),
      .clear   (buf_clear),
      .in_dat  (buf_in),
      .out_dat (buf_out),
      .full    (buf_full)
   );

   // Next-state, PC and decode-output logic; redirect is applied last so it overrides everything.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      insn_d       = insn_q;
      pc_d         = pc_q;
      insn_valid_d = insn_valid_q;
      drop_d       = drop_q;
      buf_load     = 1'b0;
      buf_unload   = 1'b0;
      buf_clear    = 1'b0;
      delivered    = 1'b0;

      case (state_q)
         FETCH_IDLE: begin
            state_d = FETCH_ISSUE;
         end
         FETCH_ISSUE: begin
            if (imem_ready) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PC_STEP;
               state_d    = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid) begin
               if (drop_q) begin
                  // Wrong-path word from before a redirect: swallow it.
                  drop_d  = 1'b0;
                  state_d = FETCH_ISSUE;
               end else if (!stall) begin
                  insn_d       = imem_rdata;
                  pc_d         = req_pc_q;
                  insn_valid_d = 1'b1;
                  delivered    = 1'b1;
                  state_d      = FETCH_ISSUE;
               end else begin
                  buf_load = 1'b1;
                  state_d  = FETCH_HOLD;
               end
            end
         end
         FETCH_HOLD: begin
            if (!stall) begin
               if (buf_full) begin
                  insn_d       = buf_out.insn;
                  pc_d         = buf_out.pc;
                  insn_valid_d = 1'b1;
                  delivered    = 1'b1;
               end
               buf_unload = 1'b1;
               state_d    = FETCH_ISSUE;
            end
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase

      // Decode consumed the previous slot and nothing new arrived: emit a bubble.
      if (!stall && !delivered) begin
         insn_valid_d = 1'b0;
      end

      if (redirect) begin
         fetch_pc_d   = align_pc(redirect_pc);
         insn_d       = insn_q;
         pc_d         = pc_q;
         insn_valid_d = 1'b0;
         buf_load     = 1'b0;
         buf_unload   = 1'b0;
         buf_clear    = 1'b1;
         case (state_q)
            FETCH_ISSUE: begin
               if (imem_ready) begin
                  // The request just accepted is wrong-path; its response must be dropped.
                  drop_d  = 1'b1;
                  state_d = FETCH_WAIT;
               end else begin
                  state_d = FETCH_ISSUE;
               end
            end
            FETCH_WAIT: begin
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = FETCH_ISSUE;
               end else begin
                  drop_d  = 1'b1;
                  state_d = FETCH_WAIT;
               end
            end
            default: begin
               drop_d  = 1'b0;
               state_d = FETCH_ISSUE;
            end
         endcase
      end
   end

   // State, PC and decode-facing registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH_IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= RESET_PC;
         insn_q       <= INSN_NOP;
         pc_q         <= RESET_PC;
         insn_valid_q <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         insn_q       <= insn_d;
         pc_q         <= pc_d;
         insn_valid_q <= insn_valid_d;
         drop_q       <= drop_d;
      end
   end

   assign imem_req   = (state_q == FETCH_ISSUE);
   assign imem_addr  = fetch_pc_q;
   assign insn       = insn_q;
   assign pc         = pc_q;
   assign insn_valid = insn_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios followed by a randomized run.
// The reference model tracks fetch at transaction level (next PC, one in-flight read, a parked word).
// Memory is emulated with a single outstanding read of configurable or random latency.
module tb_fetch;

   localparam logic [31:0] RST_PC = 32'h8002_0000;

   logic        clock;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] insn;
   logic [31:0] pc;
   logic        insn_valid;

   fetch dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .insn        (insn),
      .pc          (pc),
      .insn_valid  (insn_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic        m_idle;
   logic [31:0] m_next_pc;
   logic        m_inflight;
   logic        m_stale;
   logic [31:0] m_inflight_pc;
   logic        m_held;
   logic [31:0] m_held_insn;
   logic [31:0] m_held_pc;
   logic [31:0] m_insn;
   logic [31:0] m_pc;
   logic        m_valid;

   // Memory emulation.
   logic        mem_pending;
   int          mem_cnt;
   int          mem_lat;
   logic        spur_en;
   logic        rd_ovr_en;
   logic [31:0] rd_ovr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic exp_req();
      return !m_idle && !m_inflight && !m_held;
   endfunction

   task automatic model_reset();
      m_idle        = 1'b1;
      m_next_pc     = RST_PC;
      m_inflight    = 1'b0;
      m_stale       = 1'b0;
      m_inflight_pc = RST_PC;
      m_held        = 1'b0;
      m_held_insn   = 32'h0;
      m_held_pc     = 32'h0;
      m_insn        = 32'h0;
      m_pc          = RST_PC;
      m_valid       = 1'b0;
      mem_pending   = 1'b0;
      mem_cnt       = 0;
   endtask

   // One clock edge of the fetch stage described as: what word (if any) reaches decode this edge.
   task automatic model_step(input logic s, input logic r, input logic [31:0] rp,
                             input logic rdy, input logic rv, input logic [31:0] rd);
      logic        deliver;
      logic [31:0] d_insn;
      logic [31:0] d_pc;
      deliver = 1'b0;
      d_insn  = 32'h0;
      d_pc    = 32'h0;
      if (m_idle) begin
         m_idle = 1'b0;
      end else if (m_held) begin
         if (!s) begin
            deliver = 1'b1;
            d_insn  = m_held_insn;
            d_pc    = m_held_pc;
            m_held  = 1'b0;
         end
      end else if (m_inflight) begin
         if (rv) begin
            m_inflight = 1'b0;
            if (m_stale) begin
               m_stale = 1'b0;
            end else if (!s) begin
               deliver = 1'b1;
               d_insn  = rd;
               d_pc    = m_inflight_pc;
            end else begin
               m_held      = 1'b1;
               m_held_insn = rd;
               m_held_pc   = m_inflight_pc;
            end
         end
      end else if (rdy) begin
         m_inflight    = 1'b1;
         m_inflight_pc = m_next_pc;
         m_next_pc     = m_next_pc + 32'd4;
      end

      if (r) begin
         m_next_pc = {rp[31:2], 2'b00};
         m_valid   = 1'b0;
         m_held    = 1'b0;
         if (m_inflight) m_stale = 1'b1;
      end else if (deliver) begin
         m_insn  = d_insn;
         m_pc    = d_pc;
         m_valid = 1'b1;
      end else if (!s) begin
         m_valid = 1'b0;
      end
   endtask

   // One cycle: called just after a falling edge, returns just after the next falling edge.
   // rmode: 0 random ready, 1 ready forced high, 2 ready forced low.
   task automatic step(input logic s, input logic r, input logic [31:0] rp, input int rmode);
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        ereq;
      if (rmode == 1)      rdy = 1'b1;
      else if (rmode == 2) rdy = 1'b0;
      else                 rdy = ($urandom_range(0, 3) != 0);
      rv = 1'b0;
      rd = $urandom;
      if (mem_pending && mem_cnt == 0) begin
         rv = 1'b1;
         if (rd_ovr_en) begin
            rd        = rd_ovr;
            rd_ovr_en = 1'b0;
         end
      end else if (!mem_pending && spur_en && $urandom_range(0, 7) == 0) begin
         rv = 1'b1;
      end
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      imem_ready  = rdy;
      imem_rvalid = rv;
      imem_rdata  = rd;
      ereq = exp_req();
      #1;
      chk("imem_req", 32'(imem_req), 32'(ereq));
      chk("imem_addr", imem_addr, m_next_pc);
      @(posedge clock);
      if (mem_pending) begin
         if (mem_cnt == 0) mem_pending = 1'b0;
         else              mem_cnt--;
      end
      if (ereq && rdy) begin
         mem_pending = 1'b1;
         mem_cnt     = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
      end
      model_step(s, r, rp, rdy, rv, rd);
      #1;
      chk("insn", insn, m_insn);
      chk("pc", pc, m_pc);
      chk("insn_valid", 32'(insn_valid), 32'(m_valid));
      @(negedge clock);
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      #2;
      reset_n     = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      model_reset();
      #1;
      chk("rst_insn", insn, m_insn);
      chk("rst_pc", pc, m_pc);
      chk("rst_insn_valid", 32'(insn_valid), 32'(m_valid));
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_imem_addr", imem_addr, m_next_pc);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic run_until_req(input int bound);
      int n = 0;
      while (!exp_req() && n < bound) begin
         step(1'b0, 1'b0, 32'h0, 0);
         n++;
      end
      chk("wait_req_bound", 32'(n < bound), 32'h1);
   endtask

   task automatic run_until_rvalid_next(input int bound);
      int n = 0;
      while (!(mem_pending && mem_cnt == 0) && n < bound) begin
         step(1'b0, 1'b0, 32'h0, 0);
         n++;
      end
      chk("wait_rvalid_bound", 32'(n < bound), 32'h1);
   endtask

   initial begin
      reset_n     = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      mem_lat     = 0;
      spur_en     = 1'b0;
      rd_ovr_en   = 1'b0;
      rd_ovr      = 32'h0;
      model_reset();
      @(negedge clock);
      do_reset();

      // Streaming with always-ready memory and single-cycle responses.
      repeat (10) step(1'b0, 1'b0, 32'h0, 1);

      // Response lands under a three-cycle stall and is parked, then released.
      mem_lat = 1;
      run_until_req(10);
      rd_ovr    = 32'h2402_0005;
      rd_ovr_en = 1'b1;
      step(1'b0, 1'b0, 32'h0, 1);
      repeat (3) step(1'b1, 1'b0, 32'h0, 0);
      step(1'b0, 1'b0, 32'h0, 0);
      chk("held_insn", insn, 32'h2402_0005);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1);

      // Redirect while waiting; the response two cycles later is wrong-path.
      mem_lat = 2;
      run_until_req(10);
      step(1'b0, 1'b0, 32'h0, 1);
      step(1'b0, 1'b1, 32'h8002_0100, 0);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1);

      // Redirect in the same cycle as rvalid.
      mem_lat = 0;
      run_until_req(10);
      step(1'b0, 1'b0, 32'h0, 1);
      run_until_rvalid_next(10);
      step(1'b0, 1'b1, 32'h8002_0100, 1);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1);

      // Redirect coinciding with a request handshake, unaligned target.
      run_until_req(10);
      step(1'b0, 1'b1, 32'h8002_0103, 1);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1);

      // Address wrap at the top of the space, then a ready-low hold.
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 2);
      run_until_req(10);
      step(1'b0, 1'b0, 32'h0, 1);
      run_until_req(10);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      repeat (4) step(1'b0, 1'b0, 32'h0, 2);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1);

      // Reset in the middle of an outstanding read.
      mem_lat = 3;
      run_until_req(10);
      step(1'b0, 1'b0, 32'h0, 1);
      step(1'b0, 1'b0, 32'h0, 0);
      do_reset();
      mem_lat = 0;
      repeat (6) step(1'b0, 1'b0, 32'h0, 1);

      // Randomized traffic.
      mem_lat = -1;
      spur_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         logic        s;
         logic        r;
         logic [31:0] rp;
         s  = ($urandom_range(0, 9) < 3);
         r  = ($urandom_range(0, 19) == 0);
         rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
         if ($urandom_range(0, 499) == 0) do_reset();
         else step(s, r, rp, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
